// File: rtl/exp_hls_pkg.sv
// Shared AXIS width constants and egress arbiter state encoding.
// No timing or backpressure of its own; imported by the firewall wrapper and the egress arbiter.
package exp_hls_pkg;

   localparam int AXIS_DATA_W = 256;
   localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
   localparam int AXIS_USER_W = 12;
   localparam int AXIS_ID_W   = 3;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GRANT0 = 2'd1,
      ARB_GRANT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry registered AXIS output stage; a loaded beat appears on m_* the next cycle.
// Backpressure: ld_rdy drops while a beat is held against m_rdy low, and the payload stays stable.
module axis_out_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ld,
   input  logic [W-1:0] ld_dat,
   output logic         ld_rdy,
   output logic         m_vld,
   input  logic         m_rdy,
   output logic [W-1:0] m_dat
);

   logic         vld_q, vld_d;
   logic [W-1:0] dat_q, dat_d;

   assign ld_rdy = !vld_q || m_rdy;
   assign m_vld  = vld_q;
   assign m_dat  = dat_q;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (ld) begin
         vld_d = 1'b1;
         dat_d = ld_dat;
      end else if (m_rdy) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

endmodule

// File: rtl/cxp_egress_arbiter.sv
// Packet-atomic, credit-gated 2:1 round-robin AXIS arbiter feeding sbu2cxp; accepted beat on m_* next cycle.
// Backpressure: the granted input sees rdy only when the output register is free; the other input's rdy is held at 0.
module cxp_egress_arbiter
   import exp_hls_pkg::*;
#(
   parameter int DATA_W      = AXIS_DATA_W,
   parameter int KEEP_W      = AXIS_KEEP_W,
   parameter int USER_W      = AXIS_USER_W,
   parameter int ID_W        = AXIS_ID_W,
   parameter int CNT_W       = 32,
   parameter bit S0_LOSSLESS = 1'b0,
   parameter bit S1_LOSSLESS = 1'b0
) (
   input  logic              mlx2sbu_clk,
   input  logic              mlx2sbu_reset,
   input  logic              enable,

   input  logic              s0_vld,
   output logic              s0_rdy,
   input  logic [DATA_W-1:0] s0_tdata,
   input  logic [KEEP_W-1:0] s0_tkeep,
   input  logic              s0_tlast,
   input  logic [USER_W-1:0] s0_tuser,
   input  logic [ID_W-1:0]   s0_tid,

   input  logic              s1_vld,
   output logic              s1_rdy,
   input  logic [DATA_W-1:0] s1_tdata,
   input  logic [KEEP_W-1:0] s1_tkeep,
   input  logic              s1_tlast,
   input  logic [USER_W-1:0] s1_tuser,
   input  logic [ID_W-1:0]   s1_tid,

   output logic              m_vld,
   input  logic              m_rdy,
   output logic [DATA_W-1:0] m_tdata,
   output logic [KEEP_W-1:0] m_tkeep,
   output logic              m_tlast,
   output logic [USER_W-1:0] m_tuser,
   output logic [ID_W-1:0]   m_tid,

   input  logic              cxp2sbu_lossy_has_credits,
   input  logic              cxp2sbu_lossless_has_credits,

   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic              busy
);

   localparam int PAY_W = DATA_W + KEEP_W + USER_W + ID_W + 1;

   arb_state_t       state_q, state_d;
   logic             rr_q, rr_d;
   logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
   logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic             cred0, cred1, elig0, elig1;
   logic             out_free, acc0, acc1, ld;
   logic [PAY_W-1:0] ld_dat, m_dat;

   assign cred0 = S0_LOSSLESS ? cxp2sbu_lossless_has_credits : cxp2sbu_lossy_has_credits;
   assign cred1 = S1_LOSSLESS ? cxp2sbu_lossless_has_credits : cxp2sbu_lossy_has_credits;
   assign elig0 = enable && s0_vld && cred0;
   assign elig1 = enable && s1_vld && cred1;

   assign s0_rdy = (state_q == ARB_GRANT0) && out_free;
   assign s1_rdy = (state_q == ARB_GRANT1) && out_free;
   assign acc0   = s0_vld && s0_rdy;
   assign acc1   = s1_vld && s1_rdy;
   assign ld     = acc0 || acc1;
   assign ld_dat = acc1 ? {s1_tdata, s1_tkeep, s1_tuser, s1_tid, s1_tlast}
                        : {s0_tdata, s0_tkeep, s0_tuser, s0_tid, s0_tlast};

   // Credits and enable only matter on the IDLE->GRANT edge; a granted packet runs to tlast.
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      pkt_cnt0_d  = pkt_cnt0_q;
      pkt_cnt1_d  = pkt_cnt1_q;
      stall_cnt_d = stall_cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (elig0 && (!elig1 || !rr_q)) begin
               state_d = ARB_GRANT0;
               rr_d    = 1'b1;
            end else if (elig1) begin
               state_d = ARB_GRANT1;
               rr_d    = 1'b0;
            end
            if (enable && (s0_vld || s1_vld) && !elig0 && !elig1)
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         ARB_GRANT0: begin
            if (acc0 && s0_tlast) begin
               state_d    = ARB_IDLE;
               pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
            end
         end
         ARB_GRANT1: begin
            if (acc1 && s1_tlast) begin
               state_d    = ARB_IDLE;
               pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge mlx2sbu_clk) begin
      if (mlx2sbu_reset) begin
         state_q     <= ARB_IDLE;
         rr_q        <= 1'b0;
         pkt_cnt0_q  <= '0;
         pkt_cnt1_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         pkt_cnt0_q  <= pkt_cnt0_d;
         pkt_cnt1_q  <= pkt_cnt1_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   axis_out_reg #(
      .W (PAY_W)
   ) u_out_reg (
      .clk    (mlx2sbu_clk),
      .reset  (mlx2sbu_reset),
      .ld     (ld),
      .ld_dat (ld_dat),
      .ld_rdy (out_free),
      .m_vld  (m_vld),
      .m_rdy  (m_rdy),
      .m_dat  (m_dat)
   );

   assign {m_tdata, m_tkeep, m_tuser, m_tid, m_tlast} = m_dat;

   assign pkt_cnt0  = pkt_cnt0_q;
   assign pkt_cnt1  = pkt_cnt1_q;
   assign stall_cnt = stall_cnt_q;
   assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_cxp_egress_arbiter.sv
// Directed bench for cxp_egress_arbiter: queue-fed sources, egress beat log, immediate-assert checks.
module tb_cxp_egress_arbiter;

   localparam int DW = 256;
   localparam int KW = 32;
   localparam int UW = 12;
   localparam int IW = 3;
   localparam int CW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          mlx2sbu_reset;
   logic          enable;
   logic          lossy, lossless;
   logic          toggle_en;

   logic          s0_vld = 1'b0, s1_vld = 1'b0;
   logic          s0_rdy, s1_rdy;
   logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
   logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0;
   logic          s0_tlast = 1'b0, s1_tlast = 1'b0;
   logic [UW-1:0] s0_tuser = '0, s1_tuser = '0;
   logic [IW-1:0] s0_tid = '0, s1_tid = '0;

   logic          m_vld;
   logic          m_rdy = 1'b1;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tlast;
   logic [UW-1:0] m_tuser;
   logic [IW-1:0] m_tid;
   logic [CW-1:0] pkt_cnt0, pkt_cnt1, stall_cnt;
   logic          busy;

   cxp_egress_arbiter #(
      .DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .ID_W(IW), .CNT_W(CW),
      .S0_LOSSLESS(1'b0), .S1_LOSSLESS(1'b1)
   ) dut (
      .mlx2sbu_clk(clk), .mlx2sbu_reset(mlx2sbu_reset), .enable(enable),
      .s0_vld(s0_vld), .s0_rdy(s0_rdy), .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep),
      .s0_tlast(s0_tlast), .s0_tuser(s0_tuser), .s0_tid(s0_tid),
      .s1_vld(s1_vld), .s1_rdy(s1_rdy), .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep),
      .s1_tlast(s1_tlast), .s1_tuser(s1_tuser), .s1_tid(s1_tid),
      .m_vld(m_vld), .m_rdy(m_rdy), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
      .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tid(m_tid),
      .cxp2sbu_lossy_has_credits(lossy), .cxp2sbu_lossless_has_credits(lossless),
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .stall_cnt(stall_cnt), .busy(busy)
   );

   typedef struct packed {
      logic [15:0] d;
      logic        l;
   } beat_t;

   beat_t       q0[$];
   beat_t       q1[$];
   int          rd0 = 0, rd1 = 0;
   logic [19:0] log_rec[$];
   int          log_cyc[$];
   int          cyc = 0;
   logic        fire0 = 1'b0, fire1 = 1'b0;
   int          hold_err = 0;
   int          s1_rdy_cnt = 0;
   logic        prev_hold = 1'b0;
   logic [19:0] prev_val = '0;
   int          checks = 0;
   int          failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Mid-cycle monitor: handshakes, egress beat log, hold-stability while stalled.
   always @(negedge clk) begin
      logic [19:0] cur;
      cur   = {m_tid, m_tlast, m_tdata[15:0]};
      fire0 = s0_vld && s0_rdy;
      fire1 = s1_vld && s1_rdy;
      if (m_vld && m_rdy) begin
         log_rec.push_back(cur);
         log_cyc.push_back(cyc);
      end
      if (prev_hold && (cur !== prev_val)) hold_err = hold_err + 1;
      prev_hold = m_vld && !m_rdy;
      prev_val  = cur;
      if (s1_rdy) s1_rdy_cnt = s1_rdy_cnt + 1;
   end

   // Source drivers present the head of each queue; a reset flushes what is pending.
   always @(posedge clk) begin
      #1;
      if (mlx2sbu_reset) begin
         rd0 = q0.size();
         rd1 = q1.size();
      end else begin
         if (fire0 && rd0 < q0.size()) rd0 = rd0 + 1;
         if (fire1 && rd1 < q1.size()) rd1 = rd1 + 1;
      end
      s0_vld = rd0 < q0.size();
      if (s0_vld) begin
         s0_tdata = {240'b0, q0[rd0].d};
         s0_tlast = q0[rd0].l;
         s0_tuser = q0[rd0].d[11:0];
         s0_tkeep = '1;
         s0_tid   = 3'd0;
      end
      s1_vld = rd1 < q1.size();
      if (s1_vld) begin
         s1_tdata = {240'b0, q1[rd1].d};
         s1_tlast = q1[rd1].l;
         s1_tuser = q1[rd1].d[11:0];
         s1_tkeep = '1;
         s1_tid   = 3'd1;
      end
      m_rdy = toggle_en ? !m_rdy : 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push_pkt(input int k, input int p, input int n);
      for (int b = 0; b < n; b++) begin
         beat_t bt;
         bt.d = 16'(k * 4096 + p * 256 + b);
         bt.l = (b == n - 1);
         if (k == 0) q0.push_back(bt);
         else        q1.push_back(bt);
      end
   endtask

   function automatic logic [19:0] exp_rec(input int k, input int p, input int b, input int n);
      logic [15:0] d;
      logic        l;
      d = 16'(k * 4096 + p * 256 + b);
      l = (b == n - 1);
      return {3'(k), l, d};
   endfunction

   task automatic wait_drain(input int budget, input string tag);
      int n = 0;
      while (!(rd0 == q0.size() && rd1 == q1.size() && !m_vld && !busy) && n < budget) begin
         step();
         n++;
      end
      chk(tag, 64'(n < budget), 64'd1);
   endtask

   task automatic wait_log(input int want, input int budget, input string tag);
      int n = 0;
      while (log_rec.size() < want && n < budget) begin
         step();
         n++;
      end
      chk(tag, 64'(log_rec.size() >= want), 64'd1);
   endtask

   task automatic do_reset();
      toggle_en     = 1'b0;
      mlx2sbu_reset = 1'b1;
      step();
      step();
      mlx2sbu_reset = 1'b0;
   endtask

   initial begin
      int e, base, hb, s1c, n;
      mlx2sbu_reset = 1'b1;
      enable        = 1'b1;
      lossy         = 1'b0;
      lossless      = 1'b0;
      toggle_en     = 1'b0;
      repeat (3) step();

      chk("rst_m_vld", 64'(m_vld), 0);
      chk("rst_tdata", 64'(|m_tdata), 0);
      chk("rst_tkeep", 64'(m_tkeep), 0);
      chk("rst_tlast", 64'(m_tlast), 0);
      chk("rst_tuser", 64'(m_tuser), 0);
      chk("rst_tid", 64'(m_tid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_s0_rdy", 64'(s0_rdy), 0);
      chk("rst_s1_rdy", 64'(s1_rdy), 0);
      chk("rst_cnt0", 64'(pkt_cnt0), 0);
      chk("rst_cnt1", 64'(pkt_cnt1), 0);
      chk("rst_stall", 64'(stall_cnt), 0);
      mlx2sbu_reset = 1'b0;
      step();

      // single 4-beat packet on input 0
      lossy = 1'b1;
      step();
      e    = cyc;
      base = log_rec.size();
      push_pkt(0, 0, 4);
      wait_drain(50, "t1_drain");
      chk("t1_nbeats", 64'(log_rec.size() - base), 4);
      for (int b = 0; b < 4; b++) chk("t1_beat", 64'(log_rec[base + b]), 64'(exp_rec(0, 0, b, 4)));
      chk("t1_first_cyc", 64'(log_cyc[base] - e), 3);
      chk("t1_last_cyc", 64'(log_cyc[base + 3] - e), 6);
      chk("t1_cnt0", 64'(pkt_cnt0), 1);

      // round robin, both inputs offering 2-beat packets
      do_reset();
      lossy    = 1'b1;
      lossless = 1'b1;
      base     = log_rec.size();
      for (int p = 0; p < 4; p++) begin
         push_pkt(0, p, 2);
         push_pkt(1, p, 2);
      end
      wait_drain(200, "t2_drain");
      chk("t2_nbeats", 64'(log_rec.size() - base), 16);
      for (int i = 0; i < 8; i++)
         for (int b = 0; b < 2; b++)
            chk("t2_order", 64'(log_rec[base + 2 * i + b]), 64'(exp_rec(i % 2, i / 2, b, 2)));
      chk("t2_cnt0", 64'(pkt_cnt0), 4);
      chk("t2_cnt1", 64'(pkt_cnt1), 4);
      chk("t2_inpkt_gap", 64'(log_cyc[base + 1] - log_cyc[base]), 1);
      chk("t2_bubble", 64'(log_cyc[base + 2] - log_cyc[base + 1]), 2);

      // lossless class starved: only input 0 passes
      do_reset();
      lossy    = 1'b1;
      lossless = 1'b0;
      s1c      = s1_rdy_cnt;
      base     = log_rec.size();
      push_pkt(0, 0, 2);
      push_pkt(0, 1, 2);
      push_pkt(1, 0, 2);
      n = 0;
      while (!(rd0 == q0.size() && !m_vld) && n < 50) begin
         step();
         n++;
      end
      chk("t3_s0_done", 64'(n < 50), 1);
      repeat (4) step();
      chk("t3_nbeats", 64'(log_rec.size() - base), 4);
      chk("t3_cnt0", 64'(pkt_cnt0), 2);
      chk("t3_cnt1", 64'(pkt_cnt1), 0);
      chk("t3_s1_rdy", 64'(s1_rdy_cnt - s1c), 0);
      chk("t3_s1_pending", 64'(q1.size() - rd1), 2);
      lossless = 1'b1;
      wait_drain(50, "t3_drain");
      chk("t3_cnt1_after", 64'(pkt_cnt1), 1);
      chk("t3_s1_b0", 64'(log_rec[base + 4]), 64'(exp_rec(1, 0, 0, 2)));
      chk("t3_s1_b1", 64'(log_rec[base + 5]), 64'(exp_rec(1, 0, 1, 2)));

      // credit drop mid-packet, then credit stall counting
      do_reset();
      lossy    = 1'b1;
      lossless = 1'b0;
      base     = log_rec.size();
      push_pkt(0, 0, 5);
      wait_log(base + 2, 50, "t4_started");
      lossy = 1'b0;
      wait_drain(50, "t4_drain");
      chk("t4_nbeats", 64'(log_rec.size() - base), 5);
      for (int b = 0; b < 5; b++) chk("t4_beat", 64'(log_rec[base + b]), 64'(exp_rec(0, 0, b, 5)));
      chk("t4_cnt0", 64'(pkt_cnt0), 1);
      chk("t4_stall0", 64'(stall_cnt), 0);
      e = cyc;
      push_pkt(0, 1, 1);
      repeat (11) step();
      chk("t4_stall_cyc", 64'(cyc - e), 11);
      chk("t4_stall10", 64'(stall_cnt), 10);
      chk("t4_stall_mvld", 64'(m_vld), 0);
      chk("t4_stall_busy", 64'(busy), 0);
      enable = 1'b0;
      repeat (5) step();
      chk("t4_stall_dis", 64'(stall_cnt), 10);
      enable = 1'b1;
      lossy  = 1'b1;
      wait_drain(50, "t4_drain2");
      chk("t4_cnt0_after", 64'(pkt_cnt0), 2);
      chk("t4_late_beat", 64'(log_rec[log_rec.size() - 1]), 64'(exp_rec(0, 1, 0, 1)));

      // alternating backpressure on a 6-beat packet
      do_reset();
      lossy     = 1'b1;
      lossless  = 1'b1;
      hb        = hold_err;
      base      = log_rec.size();
      toggle_en = 1'b1;
      push_pkt(0, 0, 6);
      wait_drain(100, "t5_drain");
      toggle_en = 1'b0;
      chk("t5_nbeats", 64'(log_rec.size() - base), 6);
      for (int b = 0; b < 6; b++) chk("t5_beat", 64'(log_rec[base + b]), 64'(exp_rec(0, 0, b, 6)));
      chk("t5_hold", 64'(hold_err - hb), 0);
      chk("t5_span", 64'(log_cyc[base + 5] - log_cyc[base]), 10);
      chk("t5_cnt0", 64'(pkt_cnt0), 1);

      // reset at beat 3 of 5, then a fresh packet
      do_reset();
      lossy = 1'b1;
      base  = log_rec.size();
      push_pkt(0, 0, 5);
      wait_log(base + 3, 50, "t6_beat3");
      mlx2sbu_reset = 1'b1;
      step();
      chk("t6_m_vld", 64'(m_vld), 0);
      chk("t6_busy", 64'(busy), 0);
      chk("t6_s0_rdy", 64'(s0_rdy), 0);
      chk("t6_cnt0", 64'(pkt_cnt0), 0);
      chk("t6_stall", 64'(stall_cnt), 0);
      mlx2sbu_reset = 1'b0;
      step();
      base = log_rec.size();
      push_pkt(0, 1, 2);
      wait_drain(50, "t6_drain");
      chk("t6_nbeats", 64'(log_rec.size() - base), 2);
      chk("t6_b0", 64'(log_rec[base]), 64'(exp_rec(0, 1, 0, 2)));
      chk("t6_b1", 64'(log_rec[base + 1]), 64'(exp_rec(0, 1, 1, 2)));
      chk("t6_cnt0_after", 64'(pkt_cnt0), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
